// File: rtl/pong_pkg.sv
// Shared constants and state encoding for the brick wall.
// Geometry defaults match the ball motion logic.
package pong_pkg;

  localparam int NUM_BRICKS = 16;
  localparam int BRICK_COLS = 8;
  localparam int BRICK_ROWS = 2;

  localparam int DEF_GRID_X0 = 0;
  localparam int DEF_GRID_Y0 = 64;
  localparam int DEF_BRICK_W = 128;
  localparam int DEF_BRICK_H = 32;
  localparam int DEF_BALL_R  = 10;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/brick_hit_test.sv
// Inclusive overlap test of the ball box against one brick rectangle.
// The low edges of the ball box clamp at zero.
module brick_hit_test (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [12:0] r,
  input  logic [12:0] bx,
  input  logic [12:0] by,
  input  logic [12:0] w,
  input  logic [12:0] h,
  output logic        hit
);

  logic [12:0] x13;
  logic [12:0] y13;
  logic [12:0] xl;
  logic [12:0] xh;
  logic [12:0] yl;
  logic [12:0] yh;
  logic [12:0] bxh;
  logic [12:0] byh;

  always_comb begin
    x13 = {1'b0, x};
    y13 = {1'b0, y};
    xl  = (x13 < r) ? 13'd0 : x13 - r;
    yl  = (y13 < r) ? 13'd0 : y13 - r;
    xh  = x13 + r;
    yh  = y13 + r;
    bxh = bx + w - 13'd1;
    byh = by + h - 13'd1;
    hit = (xl <= bxh) && (bx <= xh) &&
          (yl <= byh) && (by <= yh);
  end

endmodule

// File: rtl/brick_collision.sv
// Brick wall: scans one brick per clock, retires the first hit,
// and holds a one-hot collision vector until the ball moves.
module brick_collision
  import pong_pkg::*;
#(
  parameter int GRID_X0 = DEF_GRID_X0,
  parameter int GRID_Y0 = DEF_GRID_Y0,
  parameter int BRICK_W = DEF_BRICK_W,
  parameter int BRICK_H = DEF_BRICK_H,
  parameter int BALL_R  = DEF_BALL_R
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        new_game,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  output logic [15:0] collision_det,
  output logic [15:0] bricks_alive,
  output logic [4:0]  score,
  output logic        all_cleared
);

  localparam int W_SH = $clog2(BRICK_W);
  localparam int H_SH = $clog2(BRICK_H);

  state_t      state;
  logic        pos_valid;
  logic [11:0] lx;
  logic [11:0] ly;
  logic [3:0]  idx;
  logic [3:0]  hit_idx;
  logic        hit_flag;
  logic [12:0] bx;
  logic [12:0] by;
  logic        hit;
  logic        live_hit;
  logic [15:0] retire;
  logic [15:0] alive_ret;

  always_comb begin
    bx = 13'(GRID_X0) + (13'(idx[2:0]) << W_SH);
    by = 13'(GRID_Y0) + (13'(idx[3]) << H_SH);
    live_hit  = hit && bricks_alive[idx];
    retire    = 16'd1 << hit_idx;
    alive_ret = bricks_alive & ~retire;
  end

  brick_hit_test u_hit (
    .x  (lx),
    .y  (ly),
    .r  (13'(BALL_R)),
    .bx (bx),
    .by (by),
    .w  (13'(BRICK_W)),
    .h  (13'(BRICK_H)),
    .hit(hit)
  );

  always_ff @(posedge pclk) begin
    if (reset || new_game) begin
      state         <= IDLE;
      pos_valid     <= 1'b0;
      lx            <= '0;
      ly            <= '0;
      idx           <= '0;
      hit_idx       <= '0;
      hit_flag      <= 1'b0;
      collision_det <= '0;
      bricks_alive  <= 16'hFFFF;
      score         <= '0;
      all_cleared   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!pos_valid || {x_pos, y_pos} != {lx, ly}) begin
            lx            <= x_pos;
            ly            <= y_pos;
            pos_valid     <= 1'b1;
            collision_det <= '0;
            idx           <= '0;
            hit_flag      <= 1'b0;
            state         <= SCAN;
          end
        end
        SCAN: begin
          // Lowest index wins: later hits are ignored once flagged.
          if (live_hit && !hit_flag) begin
            hit_flag <= 1'b1;
            hit_idx  <= idx;
          end
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= DONE;
        end
        DONE: begin
          if (hit_flag) begin
            collision_det <= retire;
            bricks_alive  <= alive_ret;
            score         <= score + 5'd1;
            all_cleared   <= (alive_ret == 16'd0);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_collision.sv
// Directed bench for brick_collision with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_brick_collision;

  logic        pclk = 1'b0;
  logic        reset;
  logic        new_game;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic [15:0] collision_det;
  logic [15:0] bricks_alive;
  logic [4:0]  score;
  logic        all_cleared;

  int checks = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  brick_collision dut (
    .pclk         (pclk),
    .reset        (reset),
    .new_game     (new_game),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .collision_det(collision_det),
    .bricks_alive (bricks_alive),
    .score        (score),
    .all_cleared  (all_cleared)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic move(input int x, input int y);
    x_pos = 12'(x);
    y_pos = 12'(y);
    clk(18);
  endtask

  task automatic pulse_ng();
    new_game = 1'b1;
    clk(1);
    new_game = 1'b0;
  endtask

  task automatic chk3(input string tag, input logic [15:0] det,
                      input logic [15:0] alive, input logic [4:0] sc);
    chk({tag, "_det"}, 32'(collision_det), 32'(det));
    chk({tag, "_alive"}, 32'(bricks_alive), 32'(alive));
    chk({tag, "_score"}, 32'(score), 32'(sc));
  endtask

  initial begin
    reset    = 1'b1;
    new_game = 1'b0;
    x_pos    = 12'd500;
    y_pos    = 12'd300;
    clk(3);
    chk3("reset", 16'h0000, 16'hFFFF, 5'd0);
    chk("reset_clr", 32'(all_cleared), 32'd0);
    reset = 1'b0;

    // T1: miss far below the wall
    clk(18);
    chk3("t1", 16'h0000, 16'hFFFF, 5'd0);

    // T2: bricks 1 and 9 overlap, 1 wins
    move(200, 100);
    chk3("t2a", 16'h0002, 16'hFFFD, 5'd1);
    x_pos = 12'd201;
    clk(17);
    chk("t2_lat17", 32'(collision_det), 32'h0);
    clk(1);
    chk3("t2b", 16'h0200, 16'hFDFD, 5'd2);

    // T3: inclusive edges and low clamp
    pulse_ng();
    chk3("t3_ng", 16'h0000, 16'hFFFF, 5'd0);
    move(200, 53);
    chk3("t3_y53", 16'h0000, 16'hFFFF, 5'd0);
    move(200, 54);
    chk3("t3_y54", 16'h0002, 16'hFFFD, 5'd1);
    move(5, 54);
    chk3("t3_x5", 16'h0001, 16'hFFFC, 5'd2);

    // T4: hold while ball is static
    pulse_ng();
    move(200, 100);
    chk3("t4_hit", 16'h0002, 16'hFFFD, 5'd1);
    clk(1000);
    chk3("t4_hold", 16'h0002, 16'hFFFD, 5'd1);

    // T5: new_game mid-scan aborts without a write
    pulse_ng();
    x_pos = 12'd200;
    y_pos = 12'd100;
    clk(8);
    new_game = 1'b1;
    clk(1);
    new_game = 1'b0;
    chk3("t5_abort", 16'h0000, 16'hFFFF, 5'd0);
    clk(18);
    chk3("t5_rescan", 16'h0002, 16'hFFFD, 5'd1);

    // T6: visit every brick centre in order
    pulse_ng();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] exp_alive;
      exp_alive = 16'hFFFF << (i + 1);
      move((i % 8) * 128 + 64, 80 + (i / 8) * 32);
      chk3($sformatf("t6_%0d", i), 16'd1 << i, exp_alive, 5'(i + 1));
      if (i < 15)
        chk($sformatf("t6_clr_%0d", i), 32'(all_cleared), 32'd0);
    end
    chk("t6_all_cleared", 32'(all_cleared), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
